// File: rtl/fht_adc_loader.sv
// fht_adc_loader: converts signed ADC samples and loads one frame into the FHT banks, then starts the transform and waits for it to finish
module fht_adc_loader #(
  parameter int ADC_WIDTH = 14,
  parameter int D_BIT = 18,
  parameter int A_BIT = 8,
  parameter bit ADDR_REV = 1'b0
) (
  input  logic                 iCLK,
  input  logic                 iRESET,
  input  logic                 iARM,
  input  logic [ADC_WIDTH-1:0] iADC,
  input  logic                 iVALID,
  output logic                 oREADY,
  output logic [3:0]           oWE,
  output logic [D_BIT-1:0]     oDATA,
  output logic [A_BIT-1:0]     oADDR_WR,
  output logic                 oSTART,
  input  logic                 iFHT_RDY,
  output logic                 oBUSY,
  output logic                 oDONE,
  output logic [15:0]          oDROP_CNT
);
  typedef enum logic [2:0] {IDLE, FILL, GAP, STRT, WLOW, WHIGH} state_t;
  state_t state;
  logic [A_BIT+1:0] cnt;
  logic [11:0] timer;
  logic [A_BIT-1:0] row, rev;
  logic [D_BIT-1:0] conv;
  logic accept;
  assign accept = iVALID & oREADY;
  assign row = cnt[A_BIT+1:2];
  // one guard bit of sign extension, then left-justify into D_BIT
  assign conv = D_BIT'($signed(iADC)) << (D_BIT - ADC_WIDTH - 1);
  for (genvar i = 0; i < A_BIT; i++) begin : g_rev
    assign rev[i] = row[A_BIT-1-i];
  end
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state <= IDLE;
      cnt <= '0;
      timer <= '0;
      oREADY <= 1'b0;
      oWE <= '0;
      oDATA <= '0;
      oADDR_WR <= '0;
      oSTART <= 1'b0;
      oBUSY <= 1'b0;
      oDONE <= 1'b0;
      oDROP_CNT <= '0;
    end else begin
      oWE <= accept ? 4'b0001 << cnt[1:0] : 4'b0000;
      if (accept) begin
        oDATA <= conv;
        oADDR_WR <= ADDR_REV ? rev : row;
      end
      if (iVALID && !oREADY && oDROP_CNT != 16'hFFFF) oDROP_CNT <= oDROP_CNT + 16'd1;
      oSTART <= 1'b0;
      oDONE <= 1'b0;
      case (state)
        IDLE: if (iARM) begin
          state <= FILL;
          cnt <= '0;
          oREADY <= 1'b1;
          oBUSY <= 1'b1;
          oDROP_CNT <= '0;
        end
        FILL: if (accept) begin
          cnt <= cnt + 1'b1;
          if (&cnt) begin
            state <= GAP;
            oREADY <= 1'b0;
          end
        end
        GAP: begin
          state <= STRT;
          oSTART <= 1'b1;
        end
        STRT: begin
          state <= WLOW;
          timer <= '0;
        end
        // a transform that never drops its ready gives up after 4096 cycles
        WLOW: if (!iFHT_RDY) state <= WHIGH;
          else if (&timer) begin
            state <= IDLE;
            oBUSY <= 1'b0;
          end else timer <= timer + 12'd1;
        WHIGH: if (iFHT_RDY) begin
          state <= IDLE;
          oBUSY <= 1'b0;
          oDONE <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fht_adc_loader.sv
// tb_fht_adc_loader: scoreboard bench driving natural-order and bit-reversed loaders side by side
module tb_fht_adc_loader;
  logic clk = 1'b0;
  logic rst, arm, valid, fht_rdy, acc;
  logic [13:0] adc, a;
  logic ready0, ready1, start0, start1, busy0, busy1, done0, done1;
  logic [3:0] we0, we1;
  logic [17:0] data0, data1, last_data;
  logic [7:0] addr0, addr1, last_addr, last_raddr;
  logic [15:0] drop0, drop1;
  int checks = 0, errors = 0, nk = 0, writes = 0;
  typedef struct packed {
    logic [3:0] we;
    logic [17:0] data;
    logic [7:0] addr;
    logic [7:0] raddr;
  } exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  fht_adc_loader #(.ADDR_REV(1'b0)) dut0 (
    .iCLK(clk), .iRESET(rst), .iARM(arm), .iADC(adc), .iVALID(valid), .oREADY(ready0),
    .oWE(we0), .oDATA(data0), .oADDR_WR(addr0), .oSTART(start0), .iFHT_RDY(fht_rdy),
    .oBUSY(busy0), .oDONE(done0), .oDROP_CNT(drop0)
  );
  fht_adc_loader #(.ADDR_REV(1'b1)) dut1 (
    .iCLK(clk), .iRESET(rst), .iARM(arm), .iADC(adc), .iVALID(valid), .oREADY(ready1),
    .oWE(we1), .oDATA(data1), .oADDR_WR(addr1), .oSTART(start1), .iFHT_RDY(fht_rdy),
    .oBUSY(busy1), .oDONE(done1), .oDROP_CNT(drop1)
  );
  function automatic logic [17:0] conv_model(input logic [13:0] x);
    int s;
    s = $signed(x);
    return 18'(s * 8);
  endfunction
  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic step(input logic v, input logic [13:0] x, input logic rdy_exp, output logic accepted);
    exp_t e;
    valid = v;
    adc = x;
    chk("ready", ready0, rdy_exp);
    chk("ready_rev", ready1, rdy_exp);
    accepted = v & rdy_exp;
    if (accepted) begin
      e.we = 4'b0001 << nk[1:0];
      e.data = conv_model(x);
      e.addr = 8'(nk >> 2);
      e.raddr = rev8(e.addr);
      q.push_back(e);
      nk++;
    end
    tick();
    if (we0 != 4'b0000) writes++;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("we", we0, e.we);
      chk("data", data0, e.data);
      chk("addr", addr0, e.addr);
      chk("we_rev", we1, e.we);
      chk("data_rev", data1, e.data);
      chk("addr_rev", addr1, e.raddr);
      last_data = e.data;
      last_addr = e.addr;
      last_raddr = e.raddr;
    end else begin
      chk("we_idle", we0, 4'b0000);
      chk("we_idle_rev", we1, 4'b0000);
      chk("data_hold", data0, last_data);
      chk("addr_hold", addr0, last_addr);
      chk("addr_hold_rev", addr1, last_raddr);
    end
  endtask
  task automatic chk_reset();
    chk("rst_we", we0, 4'b0000);
    chk("rst_start", start0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_ready", ready0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_data", data0, 18'h0);
    chk("rst_addr", addr0, 8'h0);
    chk("rst_drop", drop0, 16'h0);
    chk("rst_addr_rev", addr1, 8'h0);
  endtask
  initial begin
    int n, k, cyc;
    logic done_seen;
    rst = 1'b1; arm = 1'b0; valid = 1'b0; adc = '0; fht_rdy = 1'b1;
    last_data = '0; last_addr = '0; last_raddr = '0;
    repeat (3) tick();
    chk_reset();
    rst = 1'b0;
    valid = 1'b1;
    repeat (10) tick();
    chk("drop_idle", drop0, 16'd10);
    valid = 1'b0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("drop_clr", drop0, 16'd0);
    chk("busy_fill", busy0, 1'b1);
    nk = 0; writes = 0;
    for (int i = 0; i < 1024; i++) begin
      step(1'b1, 14'(i), 1'b1, acc);
      if (i == 5) begin
        chk("s5_we", we0, 4'b0010);
        chk("s5_addr", addr0, 8'd1);
        chk("s5_data", data0, 18'h00028);
      end
      if (i == 4) chk("s4_addr_rev", addr1, 8'h80);
      if (i == 1023) begin
        chk("s1023_addr_rev", addr1, 8'hFF);
        chk("s1023_we_rev", we1, 4'b1000);
      end
    end
    chk("writes_a", writes, 1024);
    chk("gap_start", start0, 1'b0);
    chk("gap_busy", busy0, 1'b1);
    step(1'b0, '0, 1'b0, acc);
    chk("start_pulse", start0, 1'b1);
    step(1'b0, '0, 1'b0, acc);
    chk("start_end", start0, 1'b0);
    n = 0; done_seen = 1'b0;
    while (busy0 === 1'b1 && n < 5000) begin
      if (done0 === 1'b1) done_seen = 1'b1;
      arm = (n == 10);
      step(1'b0, '0, 1'b0, acc);
      n++;
    end
    arm = 1'b0;
    chk("timeout_cycles", n, 4096);
    chk("timeout_no_done", done_seen, 1'b0);
    chk("timeout_done", done0, 1'b0);
    arm = 1'b1;
    step(1'b0, '0, 1'b0, acc);
    arm = 1'b0;
    nk = 0; writes = 0; k = 0; cyc = 0;
    while (k < 1024 && cyc < 10000) begin
      a = k == 0 ? 14'h2000 : k == 1 ? 14'h1FFF : k == 2 ? 14'h0001 : 14'($urandom);
      step(1'($urandom_range(0, 1)), a, 1'b1, acc);
      if (acc) begin
        if (k == 0) chk("conv_min", data0, 18'h30000);
        if (k == 1) chk("conv_max", data0, 18'h0FFF8);
        if (k == 2) chk("conv_one", data0, 18'h00008);
        k++;
      end
      cyc++;
    end
    chk("frame_b_complete", k, 1024);
    chk("writes_b", writes, 1024);
    chk("drop_b", drop0, 16'd0);
    step(1'b0, '0, 1'b0, acc);
    chk("start_b", start0, 1'b1);
    fht_rdy = 1'b0;
    repeat (300) begin
      step(1'b0, '0, 1'b0, acc);
      chk("wait_busy", busy0, 1'b1);
      chk("wait_done", done0, 1'b0);
    end
    fht_rdy = 1'b1;
    n = 0;
    while (done0 !== 1'b1 && n < 20) begin
      step(1'b0, '0, 1'b0, acc);
      n++;
    end
    chk("done_pulse", done0, 1'b1);
    step(1'b0, '0, 1'b0, acc);
    chk("done_end", done0, 1'b0);
    chk("busy_after_done", busy0, 1'b0);
    arm = 1'b1;
    step(1'b0, '0, 1'b0, acc);
    arm = 1'b0;
    nk = 0;
    for (int i = 0; i < 500; i++) step(1'b1, 14'(i), 1'b1, acc);
    valid = 1'b1;
    adc = 14'd500;
    rst = 1'b1;
    tick();
    chk_reset();
    chk("rst_queue", q.size(), 0);
    rst = 1'b0;
    valid = 1'b0;
    last_data = '0; last_addr = '0; last_raddr = '0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    nk = 0;
    step(1'b1, 14'h0123, 1'b1, acc);
    chk("restart_we", we0, 4'b0001);
    chk("restart_addr", addr0, 8'h00);
    chk("restart_addr_rev", addr1, 8'h00);
    for (int i = 1; i < 8; i++) step(1'b1, 14'($urandom), 1'b1, acc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fht_adc_loader.md
Name: fht_adc_loader

Overview:
- Upstream feeder for fht_top: takes a stream of signed ADC samples and converts each to D_BIT fixed point with one guard bit.
- Writes samples row by row into the four FHT RAM banks through fht_top's iWE/iDATA/iADDR_WR port.
- Once a full frame of 4*2^A_BIT samples is stored, pulses iSTART and waits for oRDY to close the transform.
- Reports frame completion and counts samples dropped while it is not accepting.

Parameters:
- ADC_WIDTH, 14, ADC sample width (two's complement).
- D_BIT, 18, FHT data width; must satisfy D_BIT >= ADC_WIDTH+1.
- A_BIT, 8, bank address width; BANK_SIZE = 2^A_BIT; frame N = 4*BANK_SIZE.
- ADDR_REV, 0, 1 = write address is the A_BIT bit-reverse of the row index; 0 = natural row order.

Ports:
- iCLK, in, 1, clock.
- iRESET, in, 1, synchronous reset, active-high.
- iARM, in, 1, request to capture one frame; sampled only in IDLE.
- iADC, in, ADC_WIDTH, ADC sample.
- iVALID, in, 1, iADC valid.
- oREADY, out, 1, sample accepted this cycle when iVALID & oREADY.
- oWE, out, 4, one-hot bank write enable to fht_top iWE.
- oDATA, out, D_BIT, converted sample to fht_top iDATA.
- oADDR_WR, out, A_BIT, bank row address to fht_top iADDR_WR.
- oSTART, out, 1, one-cycle start pulse to fht_top iSTART.
- iFHT_RDY, in, 1, fht_top oRDY.
- oBUSY, out, 1, high in any state except IDLE.
- oDONE, out, 1, one-cycle pulse when the transform has finished.
- oDROP_CNT, out, 16, saturating count of iVALID samples not accepted; cleared on iARM acceptance.

Behaviour:
- Reset: state = IDLE. oWE, oSTART, oDONE, oREADY and oBUSY = 0. oDATA, oADDR_WR and oDROP_CNT = 0. Sample counter = 0. Reset mid-frame abandons the frame; the RAM contents are left as they are.
- States:
  - IDLE: iARM = 1 -> FILL; clears the counter and oDROP_CNT.
  - FILL: oREADY = 1. Each accepted sample k (0..N-1) is written. The accept of k = N-1 -> GAP.
  - GAP: one cycle with no outputs active -> STRT.
  - STRT: oSTART = 1 for exactly one cycle -> WLOW.
  - WLOW: waits for iFHT_RDY = 0 -> WHIGH. A 4096-cycle timeout forces IDLE with no oDONE.
  - WHIGH: waits for iFHT_RDY = 1 -> IDLE with oDONE = 1 for one cycle.
- Write mapping:
  - bank = k[1:0]; oWE = 1 << bank.
  - row = k[A_BIT+1:2]; oADDR_WR = row, or bit_rev(row) when ADDR_REV = 1.
- Conversion: oDATA = {iADC[MSB], iADC, (D_BIT-ADC_WIDTH-1) zeros}. This is sign extension by one guard bit followed by a left shift; the numeric value is iADC*2^(D_BIT-ADC_WIDTH-1).
- Latency: oWE, oDATA and oADDR_WR are registered. They are valid in the cycle after the accept and held for exactly one cycle. With no accept, oWE = 0 and oDATA/oADDR_WR hold their last values.
- Throughput: one sample per cycle. iVALID gaps are allowed in FILL, and the counter advances only on accept.
- Drops: iVALID = 1 with oREADY = 0 (in any state other than FILL) increments oDROP_CNT, which saturates at 16'hFFFF.
- iARM outside IDLE is ignored, with no effect on the current frame.
- Wrap: the counter width is A_BIT+2. Reaching N-1 is the terminal condition; the counter never wraps inside a frame.
- Simultaneous: in the cycle the last sample is accepted, oREADY is still 1. oREADY drops in the next cycle (GAP), which guarantees the final write lands before oSTART.

Test Plan:
- Reset, iARM pulse, then stream k = 0..1023 with iADC = k, continuous valid:
  - exactly 1024 single-bit oWE pulses;
  - sample 5 -> oWE = 4'b0010, oADDR_WR = 1, oDATA = 18'h00028;
  - oSTART is one pulse two cycles after the last accept.
- Conversion: iADC = 14'h2000 -> oDATA = 18'h30000 (-65536). iADC = 14'h1FFF -> 18'h0FFF8. iADC = 14'h0001 -> 18'h00008.
- ADDR_REV = 1, sample 4 (row 1) -> oADDR_WR = 8'h80. Sample 1023 -> oADDR_WR = 8'hFF, oWE = 4'b1000.
- Random iVALID gaps (50%) during FILL:
  - same 1024 writes in order;
  - oDROP_CNT = 0;
  - after oSTART, iFHT_RDY low for 300 cycles then high -> one oDONE pulse, oBUSY = 0 in the next cycle.
- iVALID held high while IDLE for 10 cycles, then iARM -> oDROP_CNT reads 10 before iARM and 0 after. iARM during WLOW has no effect.
- iRESET asserted at sample 500 -> all outputs return to 0 in the next cycle. A new iARM restarts at sample 0, bank 0, row 0.
